// File: rtl/game_defs_pkg.sv
// rtl/game_defs_pkg.sv - shared action codes, bit indices and priority select for the player FSMs
package game_defs;

  localparam int ACT_W = 6;

  localparam int IDX_MOVE_RIGHT = 5;
  localparam int IDX_MOVE_LEFT  = 4;
  localparam int IDX_WAIT       = 3;
  localparam int IDX_JUMP       = 2;
  localparam int IDX_KICK       = 1;
  localparam int IDX_PUNCH      = 0;

  localparam logic [ACT_W-1:0] ACT_MOVE_RIGHT = 6'b100000;
  localparam logic [ACT_W-1:0] ACT_MOVE_LEFT  = 6'b010000;
  localparam logic [ACT_W-1:0] ACT_WAIT       = 6'b001000;
  localparam logic [ACT_W-1:0] ACT_JUMP       = 6'b000100;
  localparam logic [ACT_W-1:0] ACT_KICK       = 6'b000010;
  localparam logic [ACT_W-1:0] ACT_PUNCH      = 6'b000001;
  localparam logic [ACT_W-1:0] ACT_IDLE       = 6'b000000;

  typedef enum logic {
    ST_READY,
    ST_COOLDOWN
  } jump_state_t;

  // Priority order does not follow bit order: PUNCH > KICK > JUMP > RIGHT > LEFT > WAIT.
  function automatic logic [ACT_W-1:0] prio_select(input logic [ACT_W-1:0] cand);
    if (cand[IDX_PUNCH])           return ACT_PUNCH;
    else if (cand[IDX_KICK])       return ACT_KICK;
    else if (cand[IDX_JUMP])       return ACT_JUMP;
    else if (cand[IDX_MOVE_RIGHT]) return ACT_MOVE_RIGHT;
    else if (cand[IDX_MOVE_LEFT])  return ACT_MOVE_LEFT;
    else if (cand[IDX_WAIT])       return ACT_WAIT;
    else                           return ACT_IDLE;
  endfunction

endpackage

// File: rtl/player_action_encoder_debouncer.sv
// rtl/player_action_encoder_debouncer.sv - one-bit synchronizer, debouncer and rising-edge pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync_q != level) && (cnt == CNT_MAX);
  // Pulse in the cycle the level is about to go high so pending captures it on the same edge.
  assign rise = flip & ~level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_action_encoder.sv
// rtl/player_action_encoder.sv - debounced buttons to one-hot per-tick action with jump cooldown
module player_action_encoder
  import game_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JUMP_COOLDOWN   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [ACT_W-1:0] btn_raw,
  output logic [ACT_W-1:0] player_input,
  output logic             action_valid
);

  localparam int CDW = (JUMP_COOLDOWN > 0) ? $clog2(JUMP_COOLDOWN + 1) : 1;

  logic [ACT_W-1:0] dbn;
  logic [ACT_W-1:0] rise;
  logic [ACT_W-1:0] pending;
  logic [ACT_W-1:0] candidates;
  logic [ACT_W-1:0] winner;
  jump_state_t      state, state_next;
  logic [CDW-1:0]   cd_cnt, cd_next;

  for (genvar i = 0; i < ACT_W; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dbn (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[i]),
      .level  (dbn[i]),
      .rise   (rise[i])
    );
  end

  // WAIT is level-sensitive so a held WAIT keeps reaching the FSM every tick.
  always_comb begin
    candidates           = pending;
    candidates[IDX_WAIT] = pending[IDX_WAIT] | dbn[IDX_WAIT];
    if (state == ST_COOLDOWN) candidates[IDX_JUMP] = 1'b0;
    winner = prio_select(candidates);
  end

  always_comb begin
    state_next = state;
    cd_next    = cd_cnt;
    if (tick) begin
      case (state)
        ST_READY: begin
          if (winner == ACT_JUMP) begin
            cd_next    = CDW'(JUMP_COOLDOWN);
            state_next = ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (cd_cnt <= CDW'(1)) begin
            cd_next    = '0;
            state_next = ST_READY;
          end else begin
            cd_next = cd_cnt - 1'b1;
          end
        end
        default: begin
          cd_next    = '0;
          state_next = ST_READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_READY;
      cd_cnt <= '0;
    end else begin
      state  <= state_next;
      cd_cnt <= cd_next;
    end
  end

  // An edge arriving with tick belongs to the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      player_input <= ACT_IDLE;
      action_valid <= 1'b0;
    end else begin
      pending      <= tick ? rise : (pending | rise);
      action_valid <= tick;
      if (tick) player_input <= winner;
    end
  end

endmodule

// File: tb/tb_player_action_encoder.sv
// tb/tb_player_action_encoder.sv - directed self-checking bench for player_action_encoder
module tb_player_action_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] btn_raw = 6'b0;
  logic [5:0] player_input;
  logic       action_valid;
  logic [5:0] base = 6'b0;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] A_RIGHT = 6'b100000;
  localparam logic [5:0] A_LEFT  = 6'b010000;
  localparam logic [5:0] A_WAIT  = 6'b001000;
  localparam logic [5:0] A_JUMP  = 6'b000100;
  localparam logic [5:0] A_KICK  = 6'b000010;
  localparam logic [5:0] A_PUNCH = 6'b000001;
  localparam logic [5:0] A_IDLE  = 6'b000000;

  always #5 clk = ~clk;

  player_action_encoder #(
    .DEBOUNCE_CYCLES(4),
    .JUMP_COOLDOWN  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .btn_raw     (btn_raw),
    .player_input(player_input),
    .action_valid(action_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input string tag, input logic [5:0] exp);
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(action_valid), 32'd1);
    check({tag, "_action"}, 32'(player_input), 32'(exp));
    @(negedge clk) tick = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(action_valid), 32'd0);
    check({tag, "_held"}, 32'(player_input), 32'(exp));
  endtask

  task automatic press(input logic [5:0] m);
    @(negedge clk) btn_raw = base | m;
    repeat (8) @(posedge clk);
    @(negedge clk) btn_raw = base;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_input", 32'(player_input), 32'd0);
    check("reset_valid", 32'(action_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 1: reset while PUNCH is held, after one PUNCH was already issued
    @(negedge clk) btn_raw = A_PUNCH;
    repeat (8) @(posedge clk);
    do_tick("t1_pre", A_PUNCH);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t1_rst_input", 32'(player_input), 32'd0);
    check("t1_rst_valid", 32'(action_valid), 32'd0);
    @(negedge clk) begin rst_n = 1'b1; btn_raw = 6'b0; end
    do_tick("t1_post", A_IDLE);
    repeat (10) @(posedge clk);

    // 2: bounce then stable hold gives exactly one PUNCH
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) btn_raw = (i % 2 == 0) ? A_PUNCH : 6'b0;
    end
    @(negedge clk) btn_raw = A_PUNCH;
    repeat (6) @(posedge clk);
    do_tick("t2_punch", A_PUNCH);
    do_tick("t2_no_repeat", A_IDLE);
    @(negedge clk) btn_raw = 6'b0;
    repeat (10) @(posedge clk);

    // 3: priority KICK over MOVE_LEFT; losers discarded
    press(A_KICK | A_LEFT);
    do_tick("t3_kick", A_KICK);
    do_tick("t3_empty", A_IDLE);

    // 3b: MOVE_RIGHT beats MOVE_LEFT
    press(A_RIGHT | A_LEFT);
    do_tick("t3_right", A_RIGHT);

    // 4: jump cooldown of two ticks
    press(A_JUMP);
    do_tick("t4_j1", A_JUMP);
    press(A_JUMP);
    do_tick("t4_j2", A_IDLE);
    press(A_JUMP);
    do_tick("t4_j3", A_IDLE);
    press(A_JUMP);
    do_tick("t4_j4", A_JUMP);

    // 5: held WAIT repeats, PUNCH overrides for one tick
    base = A_WAIT;
    @(negedge clk) btn_raw = A_WAIT;
    repeat (8) @(posedge clk);
    do_tick("t5_w1", A_WAIT);
    press(A_PUNCH);
    do_tick("t5_w2", A_PUNCH);
    do_tick("t5_w3", A_WAIT);
    base = 6'b0;
    @(negedge clk) btn_raw = 6'b0;
    repeat (10) @(posedge clk);
    do_tick("t5_release", A_IDLE);

    // 6: KICK debounced rise coincides with tick
    @(negedge clk) btn_raw = A_KICK;
    repeat (5) @(posedge clk);
    do_tick("t6_same", A_IDLE);
    do_tick("t6_next", A_KICK);
    @(negedge clk) btn_raw = 6'b0;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
